// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Small program memory with a fetch FSM (IDLE -> READ -> VALID). A program is
//   loaded through the prog_* port while idle. Words are then fetched from the
//   address on pc and presented on a valid/ready handshake. pc_en pulses for
//   exactly one cycle per accepted instruction, which tells the program
//   counter to advance.
//
//   Optional feature: define IFETCH_PARITY_EN to store an even-parity bit with
//   every word. The bit is rechecked on each fetch and reported on parity_err.
//
// Ports
//   clk          clock, rising edge
//   n_reset      asynchronous active-low reset
//   pc           current program address from the program counter
//   pc_en        advance request to the program counter (= accept, combinational)
//   run          fetch enable
//   prog_we      program-load write strobe (honoured in IDLE only)
//   prog_addr    program-load address
//   prog_data    program-load data
//   instr_valid  instr / instr_addr hold a fetched instruction
//   instr_ready  downstream accepts the instruction
//   instr        fetched instruction word
//   instr_addr   address instr was fetched from
//   parity_err   parity mismatch on the held instruction
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic                   pc_en,
    input  logic                   run,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_addr,
    output logic                   parity_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef IFETCH_PARITY_EN
    localparam int unsigned WORD_W = INSTR_WIDTH + 1;
`else
    localparam int unsigned WORD_W = INSTR_WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  instr_addr_q, instr_addr_d;
    logic [WORD_W-1:0]      mem_q [DEPTH];
    logic [WORD_W-1:0]      wr_word;
    logic [WORD_W-1:0]      rd_word;
    logic                   mem_we;
    logic                   accept;
`ifdef IFETCH_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // Memory word formats; the parity bit sits above the instruction bits.
`ifdef IFETCH_PARITY_EN
    assign wr_word = {^prog_data, prog_data};
`else
    assign wr_word = prog_data;
`endif
    assign rd_word = mem_q[pc];

    assign accept      = (state_q == VALID) && instr_ready;
    assign pc_en       = accept;
    assign instr_valid = (state_q == VALID);
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
`ifdef IFETCH_PARITY_EN
    // The flag follows the held word; it is masked while nothing is held.
    assign parity_err  = parity_err_q & instr_valid;
`else
    assign parity_err  = 1'b0;
`endif

    // Next-state and datapath capture.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instr_addr_d = instr_addr_q;
        mem_we       = 1'b0;
`ifdef IFETCH_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A program write has priority over starting a fetch.
                if (prog_we) begin
                    mem_we = 1'b1;
                end else if (run) begin
                    state_d = READ;
                end
            end
            READ: begin
                instr_d      = rd_word[INSTR_WIDTH-1:0];
                instr_addr_d = pc;
`ifdef IFETCH_PARITY_EN
                // Even parity over data plus stored bit must reduce to 0.
                parity_err_d = ^rd_word;
`endif
                state_d      = VALID;
            end
            VALID: begin
                if (accept) begin
                    state_d = run ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and held-instruction registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            instr_q      <= '0;
            instr_addr_q <= '0;
`ifdef IFETCH_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            instr_addr_q <= instr_addr_d;
`ifdef IFETCH_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Program memory keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= wr_word;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int unsigned AW = 3;
    localparam int unsigned IW = 8;

    logic          clk = 1'b0;
    logic          n_reset;
    logic [AW-1:0] pc;
    logic          pc_en;
    logic          run;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_addr;
    logic          parity_err;

    instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .pc          (pc),
        .pc_en       (pc_en),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
        logic          par;
        int            cyc;
    } ent_t;

    ent_t          exp_q[$];
    ent_t          obs_q[$];
    logic [IW-1:0] tb_mem [8];
    int            n_pass  = 0;
    int            n_total = 0;
    int            cyc     = 0;
    int            n_pulse = 0;

    // One clock: sample just after the caller drove inputs, then take the edge.
    // The bench acts as the program counter: pc advances after each accept.
    task automatic step();
        bit acc;
        #1;
        acc = instr_valid && instr_ready;
        if (pc_en) n_pulse++;
        if (acc) obs_q.push_back('{addr: instr_addr, data: instr, par: parity_err, cyc: cyc});
        @(posedge clk);
        #1;
        cyc++;
        if (acc) pc = pc + 1'b1;
        @(negedge clk);
    endtask

    // Step until n more accepts; drop run just before the last one so the
    // block returns to IDLE afterwards.
    task automatic run_until(input int n, input int budget, output bit ok);
        int start;
        start = obs_q.size();
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (instr_valid && instr_ready && (obs_q.size() - start == n - 1)) run = 1'b0;
            step();
            if (obs_q.size() - start == n) begin
                ok = 1'b1;
                break;
            end
        end
        run = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        run       = 1'b0;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (pc_en !== 1'b0) $display("FAIL reset_pc_en: got %b want 0", pc_en); else n_pass++;
        n_total++; if (instr !== 8'h00) $display("FAIL reset_instr: got %h want 00", instr); else n_pass++;
        n_total++; if (instr_addr !== 3'd0) $display("FAIL reset_addr: got %0d want 0", instr_addr); else n_pass++;
        n_total++; if (parity_err !== 1'b0) $display("FAIL reset_parity: got %b want 0", parity_err); else n_pass++;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_fetch();
        logic [IW-1:0] prog [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        ent_t e, o [3];
        bit   ok;
        int   p0;
        for (int i = 0; i < 8; i++) load(AW'(i), prog[i]);
        obs_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back('{addr: AW'(i), data: tb_mem[i], par: 1'b0, cyc: 0});
        p0 = n_pulse;
        pc = '0; instr_ready = 1'b1; run = 1'b1;
        run_until(3, 20, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL fetch_timeout: got %0d accepts want 3", obs_q.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 3; i++) begin
                e = exp_q.pop_front();
                o[i] = obs_q.pop_front();
                n_total++; if (o[i].addr !== e.addr) $display("FAIL fetch_addr%0d: got %0d want %0d", i, o[i].addr, e.addr); else n_pass++;
                n_total++; if (o[i].data !== e.data) $display("FAIL fetch_data%0d: got %h want %h", i, o[i].data, e.data); else n_pass++;
            end
            for (int i = 1; i < 3; i++) begin
                n_total++; if (o[i].cyc - o[i-1].cyc !== 2) $display("FAIL fetch_spacing%0d: got %0d want 2", i, o[i].cyc - o[i-1].cyc); else n_pass++;
            end
        end
        exp_q.delete();
        n_total++; if (n_pulse - p0 !== 3) $display("FAIL fetch_pulses: got %0d want 3", n_pulse - p0); else n_pass++;
        step();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL fetch_idle_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (pc_en !== 1'b0) $display("FAIL fetch_idle_pc_en: got %b want 0", pc_en); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   p0, o0;
        ent_t o;
        obs_q.delete();
        pc = 3'd3; instr_ready = 1'b0; run = 1'b1;
        wait_valid(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL bp_timeout: got valid %b want 1", instr_valid); else n_pass++;
        p0 = n_pulse;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (instr_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, instr_valid); else n_pass++;
            n_total++; if (instr !== tb_mem[3]) $display("FAIL bp_instr%0d: got %h want %h", i, instr, tb_mem[3]); else n_pass++;
        end
        n_total++; if (n_pulse !== p0) $display("FAIL bp_no_pulse: got %0d want %0d", n_pulse - p0, 0); else n_pass++;
        // Drop run and attempt a program write while VALID, then accept.
        run = 1'b0; prog_we = 1'b1; prog_addr = 3'd3; prog_data = 8'hFF; instr_ready = 1'b1;
        o0 = obs_q.size();
        step();
        prog_we = 1'b0;
        n_total++; if (obs_q.size() !== o0 + 1) $display("FAIL bp_accept: got %0d want %0d", obs_q.size(), o0 + 1); else n_pass++;
        n_total++; if (n_pulse - p0 !== 1) $display("FAIL bp_one_pulse: got %0d want 1", n_pulse - p0); else n_pass++;
        step();
        n_total++; if (instr_valid !== 1'b0) $display("FAIL bp_idle: got %b want 0", instr_valid); else n_pass++;
        obs_q.delete();
        pc = 3'd3; run = 1'b1;
        run_until(1, 10, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL bp_refetch_timeout: got %0d want 1", obs_q.size()); else n_pass++;
        if (ok) begin
            o = obs_q.pop_front();
            n_total++; if (o.data !== tb_mem[3]) $display("FAIL bp_mem_kept: got %h want %h", o.data, tb_mem[3]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit            ok;
        ent_t          o;
        logic [AW-1:0] a;
        int            p0;
        // Reset while READ.
        obs_q.delete();
        pc = 3'd5; instr_ready = 1'b1; run = 1'b1;
        step();
        p0 = n_reset ? n_pulse : 0;
        n_reset = 1'b0;
        #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_read_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (pc_en !== 1'b0) $display("FAIL rst_read_pc_en: got %b want 0", pc_en); else n_pass++;
        n_total++; if (instr !== 8'h00) $display("FAIL rst_read_instr: got %h want 00", instr); else n_pass++;
        n_total++; if (instr_addr !== 3'd0) $display("FAIL rst_read_addr: got %0d want 0", instr_addr); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        a = pc;
        run = 1'b1;
        run_until(1, 10, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rst_read_refetch: got %0d want 1", obs_q.size()); else n_pass++;
        if (ok) begin
            o = obs_q.pop_front();
            n_total++; if (o.addr !== a) $display("FAIL rst_read_re_addr: got %0d want %0d", o.addr, a); else n_pass++;
            n_total++; if (o.data !== tb_mem[a]) $display("FAIL rst_read_re_data: got %h want %h", o.data, tb_mem[a]); else n_pass++;
        end
        n_total++; if (n_pulse - p0 !== 1) $display("FAIL rst_read_pulses: got %0d want 1", n_pulse - p0); else n_pass++;
        // Reset while VALID.
        instr_ready = 1'b0; run = 1'b1;
        wait_valid(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rst_valid_timeout: got %b want 1", instr_valid); else n_pass++;
        n_reset = 1'b0;
        #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (instr !== 8'h00) $display("FAIL rst_valid_instr: got %h want 00", instr); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        a = pc;
        instr_ready = 1'b1; run = 1'b1;
        run_until(1, 10, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rst_valid_refetch: got %0d want 1", obs_q.size()); else n_pass++;
        if (ok) begin
            o = obs_q.pop_front();
            n_total++; if (o.addr !== a) $display("FAIL rst_valid_re_addr: got %0d want %0d", o.addr, a); else n_pass++;
            n_total++; if (o.data !== tb_mem[a]) $display("FAIL rst_valid_re_data: got %h want %h", o.data, tb_mem[a]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit   ok;
        ent_t e, o;
        logic [AW-1:0] seq [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        obs_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back('{addr: seq[i], data: tb_mem[seq[i]], par: 1'b0, cyc: 0});
        pc = 3'd6; instr_ready = 1'b1; run = 1'b1;
        run_until(4, 30, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL wrap_timeout: got %0d want 4", obs_q.size()); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_total++; if (o.addr !== e.addr) $display("FAIL wrap_addr%0d: got %0d want %0d", i, o.addr, e.addr); else n_pass++;
                n_total++; if (o.data !== e.data) $display("FAIL wrap_data%0d: got %h want %h", i, o.data, e.data); else n_pass++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_parity();
        bit   ok;
        ent_t o;
        logic exp_par [3];
`ifdef IFETCH_PARITY_EN
        dut.mem_q[4][IW] = ~dut.mem_q[4][IW];
        exp_par = '{1'b0, 1'b1, 1'b0};
`else
        exp_par = '{1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            obs_q.delete();
            pc = AW'(i + 3); instr_ready = 1'b1; run = 1'b1;
            run_until(1, 10, ok);
            n_total++; if (ok !== 1'b1) $display("FAIL par_timeout%0d: got %0d want 1", i, obs_q.size()); else n_pass++;
            if (ok) begin
                o = obs_q.pop_front();
                n_total++; if (o.par !== exp_par[i]) $display("FAIL par_addr%0d: got %b want %b", i + 3, o.par, exp_par[i]); else n_pass++;
            end
        end
        step();
        n_total++; if (parity_err !== 1'b0) $display("FAIL par_idle: got %b want 0", parity_err); else n_pass++;
    endtask

    initial begin
        run         = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        instr_ready = 1'b0;
        pc          = '0;
        test_reset();
        test_fetch();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_parity();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: width of program address and of pc input.
REQ-002 Parameter INSTR_WIDTH, default 8: width of one instruction word.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port n_reset  input  1  reset, asynchronous assert, active-low; one clock; reset asynchronous and active-low.
REQ-005 Port pc  input  ADDR_WIDTH  current program address from the program counter.
REQ-006 Port pc_en  output  1  advance request to the program counter.
REQ-007 Port run  input  1  fetch enable; 0 halts fetching after any held instruction is accepted.
REQ-008 Port prog_we  input  1  program-load write strobe.
REQ-009 Port prog_addr  input  ADDR_WIDTH  program-load address.
REQ-010 Port prog_data  input  INSTR_WIDTH  program-load data.
REQ-011 Port instr_valid  output  1  instr/instr_addr hold a fetched instruction.
REQ-012 Port instr_ready  input  1  downstream decode accepts instruction.
REQ-013 Port instr  output  INSTR_WIDTH  fetched instruction word.
REQ-014 Port instr_addr  output  ADDR_WIDTH  address instr was fetched from.
REQ-015 Port parity_err  output  1  parity mismatch on held instruction (see Configuration).

Function
REQ-016 Internal memory SHALL hold 2**ADDR_WIDTH words of INSTR_WIDTH bits, synchronous write, synchronous read.
REQ-017 FSM states SHALL be IDLE, READ, VALID.
REQ-018 IDLE: instr_valid=0; if run=1 and prog_we=0 -> READ, else stay.
REQ-019 IDLE with prog_we=1: mem[prog_addr] <= prog_data at the edge; prog_we SHALL be ignored in READ and VALID.
REQ-020 READ: at the edge, instr <= mem[pc], instr_addr <= pc, -> VALID (one-cycle read latency).
REQ-021 VALID: instr_valid=1; instr, instr_addr, parity_err SHALL remain stable until accepted.
REQ-022 Accept = instr_valid & instr_ready; pc_en SHALL equal accept combinationally, exactly one cycle per accepted instruction.
REQ-023 VALID on accept: -> READ if run=1, else -> IDLE; without accept stay VALID regardless of run.
REQ-024 pc_en SHALL be 0 in IDLE and READ; block SHALL never request advance without an accept.
REQ-025 Peak throughput SHALL be one instruction per two cycles (READ, VALID alternating with instr_ready tied 1).
REQ-026 PC wrap-around is the program counter's concern; fetch SHALL read whatever pc presents, including 0 after wrap.
REQ-027 run falling in READ SHALL still complete the fetch into VALID.

Reset
REQ-028 n_reset=0 SHALL immediately force state IDLE, instr_valid=0, pc_en=0, instr=0, instr_addr=0, parity_err=0.
REQ-029 Reset mid-operation (READ or VALID) SHALL discard the in-flight instruction; no pc_en pulse.
REQ-030 Memory contents SHALL be unaffected by reset.
REQ-031 After n_reset deasserts, first READ SHALL occur no earlier than the first edge with run=1.

Configuration
REQ-032 Macro IFETCH_PARITY_EN defined: each word stores an extra even-parity bit computed from prog_data on write; in READ parity is rechecked and parity_err <= mismatch, held with the instruction; 0 when instr_valid=0.
REQ-033 Macro IFETCH_PARITY_EN undefined: no parity storage or logic; parity_err SHALL be tied 0.

Verification
REQ-034 Load mem[0..2]=8'h11,8'h22,8'h33 in IDLE, run=1, instr_ready=1, pc from counter -> instr 11,22,33 with instr_addr 0,1,2, one pc_en per instruction, valid every other cycle.
REQ-035 Backpressure: instr_ready=0 for 5 cycles in VALID -> instr_valid held 1, instr stable, pc_en 0 throughout; ready=1 -> single pc_en pulse.
REQ-036 run dropped in VALID then ready=1 -> accept, one pc_en, state IDLE, instr_valid 0 next cycle; prog_we during VALID leaves memory unchanged.
REQ-037 n_reset pulsed low in READ and in VALID -> outputs zero asynchronously before next edge, no pc_en, refetch resumes from current pc.
REQ-038 ADDR_WIDTH=3, run continuous, pc wraps 7->0 -> instr_addr sequence 6,7,0,1 with mem contents matching.
REQ-039 With IFETCH_PARITY_EN, force stored parity bit of mem[4] inverted -> fetch of addr 4 gives parity_err=1, other addresses 0; without macro parity_err always 0.
